// File: rtl/hub_dma.sv
`default_nettype none
// ============================================================================
//  Module   : hub_dma
//  Purpose  : Single-channel DMA between a time-slotted hub bus and a pair of
//             32-bit valid/ready streams. Reads move hub longs to out_*,
//             writes move in_* beats to the hub. Length 0..511 longs, 14-bit
//             long address that wraps at 3FFF.
//  Ports    : clk_cog, res           - clock, synchronous active-high reset
//             start/dir/addr/count   - transfer request (sampled in IDLE)
//             busy, done             - status / one-cycle completion pulse
//             ena_bus, bus_*         - hub slot enable and access request
//             bus_q                  - hub read data (one cycle after accept)
//             in_data/valid/ready    - write-data stream (sink)
//             out_data/valid/ready   - read-data stream (source)
//  Revision : 1.0  initial release
// ============================================================================
module hub_dma (
    input  logic        clk_cog,
    input  logic        res,
    input  logic        ena_bus,
    input  logic        start,
    input  logic        dir,
    input  logic [13:0] addr,
    input  logic [8:0]  count,
    output logic        busy,
    output logic        done,
    output logic        bus_req,
    output logic        bus_w,
    output logic [3:0]  bus_wb,
    output logic [13:0] bus_a,
    output logic [31:0] bus_d,
    input  logic [31:0] bus_q,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state, w_state_n;
    logic        r_dir, w_dir_n;
    logic [8:0]  r_left, w_left_n;       // accesses still to be accepted
    logic        r_inflight, w_inflight_n;
    logic [1:0]  r_occ, w_occ_n;         // read FIFO occupancy (0..2)
    logic [31:0] r_tail, w_tail_n;       // second FIFO entry; head is r_out_data
    logic        w_hold_n;               // write holding register full

    logic        r_busy, r_done, r_bus_req, r_bus_w, r_in_ready, r_out_valid;
    logic [3:0]  r_bus_wb;
    logic [13:0] r_bus_a, w_addr_n;
    logic [31:0] r_bus_d, w_data_n;
    logic [31:0] r_out_data, w_head_n;

    logic        w_busy_n, w_req_n, w_w_n, w_in_ready_n;
    logic        w_accept, w_push, w_pop, w_fire_in;

    assign w_accept  = ena_bus & r_bus_req;
    assign w_push    = r_inflight;           // bus_q is valid exactly now
    assign w_pop     = r_out_valid & out_ready;
    assign w_fire_in = in_valid & r_in_ready;

    // ---------------- control / next-state ----------------
    always_comb begin
        w_state_n    = r_state;
        w_dir_n      = r_dir;
        w_left_n     = r_left;
        w_addr_n     = r_bus_a;
        w_data_n     = r_bus_d;
        w_hold_n     = r_bus_req & r_bus_w;
        // bus_req is only ever high in RUN, so an accepted read is in flight
        w_inflight_n = w_accept & ~r_dir;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_dir_n   = dir;
                    w_left_n  = count;
                    w_addr_n  = addr;
                    w_state_n = (count == 9'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // Load and accept are mutually exclusive: in_ready requires
                // an empty holding register, acceptance requires a full one.
                if (r_dir && w_fire_in) begin
                    w_data_n = in_data;
                    w_hold_n = 1'b1;
                end
                if (w_accept) begin
                    w_addr_n = r_bus_a + 14'd1;
                    w_left_n = r_left - 9'd1;
                    w_hold_n = 1'b0;
                    if (r_left == 9'd1)
                        w_state_n = r_dir ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_occ == 2'd0 && !r_inflight)
                    w_state_n = S_DONE;
            end
            S_DONE:  w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    // ---------------- read FIFO (2 entries, head drives out_data) ----------------
    always_comb begin
        w_occ_n  = r_occ;
        w_head_n = r_out_data;
        w_tail_n = r_tail;
        case ({w_push, w_pop})
            2'b10: begin
                if (r_occ == 2'd0) begin
                    w_head_n = bus_q;
                    w_occ_n  = 2'd1;
                end else begin
                    w_tail_n = bus_q;
                    w_occ_n  = 2'd2;
                end
            end
            2'b01: begin
                w_head_n = r_tail;
                w_occ_n  = r_occ - 2'd1;
            end
            2'b11: begin
                if (r_occ == 2'd1) begin
                    w_head_n = bus_q;
                end else begin
                    w_head_n = r_tail;
                    w_tail_n = bus_q;
                end
            end
            default: ;
        endcase
    end

    // ---------------- registered outputs ----------------
    always_comb begin
        w_busy_n = (w_state_n == S_RUN) || (w_state_n == S_DRAIN);
        // Reads are throttled so that every in-flight read has a FIFO slot.
        w_req_n  = (w_state_n == S_RUN) &&
                   (w_dir_n ? w_hold_n
                            : ((w_left_n != 9'd0) &&
                               (({1'b0, w_inflight_n} + w_occ_n) < 2'd2)));
        w_w_n        = w_req_n & w_dir_n;
        w_in_ready_n = (w_state_n == S_RUN) && w_dir_n && !w_hold_n &&
                       (w_left_n != 9'd0);
    end

    always_ff @(posedge clk_cog) begin
        if (res) begin
            r_state     <= S_IDLE;
            r_dir       <= 1'b0;
            r_left      <= 9'd0;
            r_inflight  <= 1'b0;
            r_occ       <= 2'd0;
            r_tail      <= 32'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_w     <= 1'b0;
            r_bus_wb    <= 4'b0000;
            r_bus_a     <= 14'd0;
            r_bus_d     <= 32'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'd0;
        end else begin
            r_state     <= w_state_n;
            r_dir       <= w_dir_n;
            r_left      <= w_left_n;
            r_inflight  <= w_inflight_n;
            r_occ       <= w_occ_n;
            r_tail      <= w_tail_n;
            r_busy      <= w_busy_n;
            r_done      <= (r_state == S_DONE);
            r_bus_req   <= w_req_n;
            r_bus_w     <= w_w_n;
            r_bus_wb    <= {4{w_w_n}};
            r_bus_a     <= w_addr_n;
            r_bus_d     <= w_data_n;
            r_in_ready  <= w_in_ready_n;
            r_out_valid <= (w_occ_n != 2'd0);
            r_out_data  <= w_head_n;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign bus_req   = r_bus_req;
    assign bus_w     = r_bus_w;
    assign bus_wb    = r_bus_wb;
    assign bus_a     = r_bus_a;
    assign bus_d     = r_bus_d;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_hub_dma.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hub_dma
//  Purpose  : Self-checking bench for hub_dma. A hub model answers reads from
//             a synthetic memory and checks every accepted access against a
//             scoreboard queue; read beats are checked against a second queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hub_dma;

    logic        clk_cog = 1'b0;
    logic        res = 1'b1;
    logic        ena_bus = 1'b0;
    logic        start = 1'b0;
    logic        dir = 1'b0;
    logic [13:0] addr = 14'd0;
    logic [8:0]  count = 9'd0;
    logic        busy, done, bus_req, bus_w, in_ready, out_valid;
    logic [3:0]  bus_wb;
    logic [13:0] bus_a;
    logic [31:0] bus_d, out_data;
    logic [31:0] bus_q = 32'd0;
    logic [31:0] in_data = 32'd0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;

    hub_dma dut (
        .clk_cog  (clk_cog),
        .res      (res),
        .ena_bus  (ena_bus),
        .start    (start),
        .dir      (dir),
        .addr     (addr),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .bus_req  (bus_req),
        .bus_w    (bus_w),
        .bus_wb   (bus_wb),
        .bus_a    (bus_a),
        .bus_d    (bus_d),
        .bus_q    (bus_q),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk_cog = ~clk_cog;

    typedef struct {
        logic [13:0] a;
        logic        w;
        logic [31:0] d;
    } acc_t;

    typedef struct {
        logic        dir;
        logic [13:0] addr;
        logic [8:0]  count;
        int          period;     // ena_bus high once every 'period' cycles
        int          bp;         // out_ready held low for this many cycles
        logic [13:0] exp_final;  // bus_a after the last acceptance
    } vec_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   acc_cnt = 0;
    acc_t exp_acc[$];
    logic [31:0] exp_out[$];

    function automatic logic [31:0] memv(input logic [13:0] a);
        return {4'hD, a, a ^ 14'h1555};
    endfunction

    function automatic logic [31:0] wd(input int i);
        return (i == 0) ? 32'hA5A5A5A5 : 32'(i);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " busy"},      32'(busy),      32'd0);
        chk({tag, " done"},      32'(done),      32'd0);
        chk({tag, " bus_req"},   32'(bus_req),   32'd0);
        chk({tag, " bus_w"},     32'(bus_w),     32'd0);
        chk({tag, " bus_wb"},    32'(bus_wb),    32'd0);
        chk({tag, " bus_a"},     32'(bus_a),     32'd0);
        chk({tag, " bus_d"},     bus_d,          32'd0);
        chk({tag, " in_ready"},  32'(in_ready),  32'd0);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " out_data"},  out_data,       32'd0);
    endtask

    // ---------------- hub model ----------------
    logic        h_pend = 1'b0;
    logic [13:0] h_pa;
    logic [31:0] h_pd;
    logic        h_pw;
    logic [13:0] h_ra;
    acc_t        h_e;

    always @(posedge clk_cog) begin
        // A request left waiting by a missed slot must be held unchanged.
        if (h_pend && !res) begin
            chk("hold bus_req", 32'(bus_req), 32'd1);
            chk("hold bus_a",   32'(bus_a),   32'(h_pa));
            if (h_pw) chk("hold bus_d", bus_d, h_pd);
        end
        h_pend = bus_req && !ena_bus && !res;
        h_pa   = bus_a;
        h_pd   = bus_d;
        h_pw   = bus_w;
        if (ena_bus && bus_req && !res) begin
            acc_cnt++;
            if (exp_acc.size() == 0) begin
                chk("unexpected access", 32'd1, 32'd0);
            end else begin
                h_e = exp_acc.pop_front();
                chk("acc bus_a",  32'(bus_a),  32'(h_e.a));
                chk("acc bus_w",  32'(bus_w),  32'(h_e.w));
                chk("acc bus_wb", 32'(bus_wb), h_e.w ? 32'hF : 32'h0);
                if (h_e.w) chk("acc bus_d", bus_d, h_e.d);
            end
            if (!bus_w) begin
                h_ra = bus_a;
                #1 bus_q = memv(h_ra);
            end
        end
    end

    // ---------------- one transfer ----------------
    task automatic run_xfer(input logic d, input logic [13:0] a, input logic [8:0] n,
                            input int period, input int bp, input logic [13:0] fin,
                            input int stop_beats);
        int   wi, beats, ndone;
        bit   finished, fire_in, fire_out;
        acc_t e;
        wi = 0; beats = 0; ndone = 0; finished = 0;
        acc_cnt = 0;
        for (int i = 0; i < int'(n); i++) begin
            e.a = a + 14'(i);
            e.w = d;
            e.d = d ? wd(i) : 32'h0;
            exp_acc.push_back(e);
            if (!d) exp_out.push_back(memv(e.a));
        end
        @(negedge clk_cog);
        start = 1'b1; dir = d; addr = a; count = n;
        ena_bus = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
            @(negedge clk_cog);
            start = 1'b0;
            if (cyc == 0) chk("busy after start", 32'(busy), 32'd1);
            if (done) begin ndone++; finished = 1; end
            if (bp > 0 && cyc == bp - 1 && !d) begin
                chk("bp accepted reads", 32'(acc_cnt), 32'd2);
                chk("bp bus_req low",    32'(bus_req), 32'd0);
            end
            ena_bus   = (period <= 1) || (cyc % period == 0);
            out_ready = (cyc >= bp);
            in_valid  = d && (wi < int'(n));
            in_data   = wd(wi);
            fire_in   = in_valid && in_ready;
            fire_out  = out_valid && out_ready;
            if (fire_in) wi++;
            if (fire_out) begin
                beats++;
                if (exp_out.size() == 0) chk("extra out beat", 32'd1, 32'd0);
                else chk("out data", out_data, exp_out.pop_front());
            end
            if (stop_beats != 0 && beats >= stop_beats) finished = 1;
        end
        in_valid = 1'b0;
        if (stop_beats != 0) return;
        if (!finished) chk("transfer timeout", 32'd0, 32'd1);
        @(negedge clk_cog);
        chk("done one cycle",  32'(done),           32'd0);
        chk("busy after done", 32'(busy),           32'd0);
        chk("done pulses",     32'(ndone),          32'd1);
        chk("accept count",    32'(acc_cnt),        32'(n));
        chk("accesses left",   32'(exp_acc.size()), 32'd0);
        chk("out beats left",  32'(exp_out.size()), 32'd0);
        chk("final bus_a",     32'(bus_a),          32'(fin));
    endtask

    // ---------------- stimulus ----------------
    vec_t vecs[5];
    bit   saw;

    initial begin
        vecs[0] = '{dir: 1'b0, addr: 14'h0010, count: 9'd4, period: 1,  bp: 0,  exp_final: 14'h0014};
        vecs[1] = '{dir: 1'b1, addr: 14'h3FFE, count: 9'd3, period: 1,  bp: 0,  exp_final: 14'h0001};
        vecs[2] = '{dir: 1'b0, addr: 14'h0100, count: 9'd8, period: 1,  bp: 20, exp_final: 14'h0108};
        vecs[3] = '{dir: 1'b1, addr: 14'h0200, count: 9'd5, period: 16, bp: 0,  exp_final: 14'h0205};
        vecs[4] = '{dir: 1'b0, addr: 14'h3FFD, count: 9'd5, period: 3,  bp: 0,  exp_final: 14'h0002};

        repeat (3) @(negedge clk_cog);
        chk_reset("reset");
        res = 1'b0;

        for (int v = 0; v < 5; v++)
            run_xfer(vecs[v].dir, vecs[v].addr, vecs[v].count,
                     vecs[v].period, vecs[v].bp, vecs[v].exp_final, 0);

        // count = 0: done two cycles after start, no bus request at all
        @(negedge clk_cog);
        start = 1'b1; dir = 1'b0; addr = 14'h1234; count = 9'd0; ena_bus = 1'b1;
        @(negedge clk_cog);
        start = 1'b0;
        chk("cnt0 done early", 32'(done),    32'd0);
        chk("cnt0 bus_req",    32'(bus_req), 32'd0);
        @(negedge clk_cog);
        chk("cnt0 done pulse", 32'(done),    32'd1);
        chk("cnt0 busy",       32'(busy),    32'd0);
        chk("cnt0 bus_req 2",  32'(bus_req), 32'd0);
        @(negedge clk_cog);
        chk("cnt0 done clear", 32'(done),    32'd0);

        // reset in the middle of a 6-long read, after two beats
        run_xfer(1'b0, 14'h0040, 9'd6, 1, 0, 14'h0000, 2);
        @(negedge clk_cog);
        res = 1'b1;
        @(negedge clk_cog);
        chk_reset("abort");
        res = 1'b0;
        exp_acc.delete();
        exp_out.delete();
        saw = 0;
        repeat (8) begin
            @(negedge clk_cog);
            if (done || bus_req) saw = 1;
        end
        chk("abort no done/req", 32'(saw), 32'd0);

        run_xfer(1'b0, 14'h0050, 9'd3, 1, 0, 14'h0053, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/hub_dma.md
HUB_DMA -- requirements
Module: hub_dma

Interface
REQ-001 Parameter: none; transfer length, address and direction are run-time inputs.
REQ-002 clk_cog  in  1  single clock; all state updates on its rising edge.
REQ-003 res  in  1  reset, synchronous, active-high.
REQ-004 ena_bus  in  1  hub slot enable; the hub samples bus_* at any rising edge where ena_bus=1.
REQ-005 start  in  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-006 dir  in  1  0 = read (hub -> stream out), 1 = write (stream in -> hub); captured with start.
REQ-007 addr  in  14  starting long address; captured with start.
REQ-008 count  in  9  number of longs, 0..511; captured with start.
REQ-009 busy  out  1  high from the cycle after an accepted start until done.
REQ-010 done  out  1  one-cycle pulse at transfer completion.
REQ-011 bus_req  out  1  access pending on the hub bus.
REQ-012 bus_w  out  1  pending access is a write.
REQ-013 bus_wb  out  4  byte enables; 4'b1111 whenever bus_w=1, else 4'b0000.
REQ-014 bus_a  out  14  long address of the pending access.
REQ-015 bus_d  out  32  write data.
REQ-016 bus_q  in  32  hub read data; valid from the cycle after an accepted read until the next ena_bus edge.
REQ-017 in_data / in_valid / in_ready  in 32 / in 1 / out 1  write-data stream; a beat transfers when in_valid & in_ready.
REQ-018 out_data / out_valid / out_ready  out 32 / out 1 / in 1  read-data stream; a beat transfers when out_valid & out_ready.

Function
REQ-019 States: IDLE, RUN, DRAIN, DONE; all bus_* outputs, busy, out_valid and in_ready registered.
REQ-020 IDLE: start=1 captures dir/addr/count. count=0 -> DONE; otherwise -> RUN. start is ignored outside IDLE.
REQ-021 Access accepted = rising edge with ena_bus=1 and bus_req=1; bus_a/bus_w/bus_d are held stable until acceptance.
REQ-022 After each acceptance: bus_a increments by 1 modulo 2^14 (3FFF wraps to 0000); remaining count decrements.
REQ-023 Write: 1-entry holding register. in_ready=1 only when the register is empty and beats remain un-fetched. A beat loads bus_d and sets bus_req=bus_w=1; acceptance clears the register.
REQ-024 Write: once the last write is accepted -> DONE.
REQ-025 Read: 2-entry output FIFO. bus_req=1 (bus_w=0) only when FIFO occupancy + in-flight reads < 2 and reads remain.
REQ-026 Read: bus_q is captured into the FIFO exactly one cycle after acceptance; at most one read in flight.
REQ-027 Read: after the last acceptance -> DRAIN. DRAIN -> DONE once the FIFO is empty and nothing is in flight.
REQ-028 out_valid = FIFO non-empty; out_data = FIFO head. A simultaneous push and pop keeps occupancy unchanged.
REQ-029 DONE: done=1 for exactly one cycle, then IDLE; busy=0 in that cycle.
REQ-030 ena_bus=0 stalls the transfer without loss; it may stay low indefinitely.
REQ-031 bus_req=0 in IDLE, DONE and DRAIN; the hub may still pulse ena_bus in these states with no effect on state.

Reset
REQ-032 res=1 at any edge, including mid-transfer: state=IDLE, FIFO and holding register emptied, in-flight read discarded.
REQ-033 Reset values: busy=0, done=0, bus_req=0, bus_w=0, bus_wb=0, bus_a=0, bus_d=0, in_ready=0, out_valid=0, out_data=0.
REQ-034 No done pulse is generated for a transfer aborted by reset.

Verification
REQ-035 Read: dir=0, addr=0x0010, count=4, ena_bus=1 always, out_ready=1 -> bus_a 0x0010..0x0013, four out beats equal to the memory contents, one done pulse.
REQ-036 Write wrap: dir=1, addr=0x3FFE, count=3, data 0xA5A5A5A5/1/2 -> writes to 0x3FFE, 0x3FFF, 0x0000 with bus_wb=1111, then done.
REQ-037 Backpressure: read count=8 with out_ready=0 for 20 cycles -> exactly 2 accepted reads, then no bus_req; after release, all 8 beats arrive in order.
REQ-038 Sparse slots: ena_bus=1 once every 16 cycles, write count=5 -> 5 accepted writes; bus_a and bus_d stable between slots.
REQ-039 count=0 -> done pulse two cycles after start, no bus_req ever asserted.
REQ-040 res=1 mid-read after 2 of 6 beats -> all outputs at reset values next cycle, no done; a new start then runs normally.
